// File: rtl/dscnn_weight_pkg.sv
// Shared constants and the layer descriptor table for the DS-CNN weight store.
// Bases are cumulative sums of the lengths; the last layer ends at 0x10C7.
package dscnn_weight_pkg;

   localparam int unsigned DEPTH      = 4296;
   localparam int unsigned ADDR_W     = 13;
   localparam int unsigned DATA_W     = 8;
   localparam int unsigned NUM_LAYERS = 10;
   localparam int unsigned IDX_W      = 10;

   typedef enum logic [3:0] {
      FIRST_CONV, DW0, PW0, DW1, PW1, DW2, PW2, DW3, PW3, CLASSIFIER
   } layer_e;

   localparam logic [ADDR_W-1:0] LAYER_BASE [NUM_LAYERS] = '{
      13'h000, 13'h3C0, 13'h498, 13'h6D8, 13'h7B0,
      13'h9F0, 13'hAC8, 13'hD08, 13'hDE0, 13'h1020
   };

   localparam logic [IDX_W-1:0] LAYER_LEN [NUM_LAYERS] = '{
      10'd960, 10'd216, 10'd576, 10'd216, 10'd576,
      10'd216, 10'd576, 10'd216, 10'd576, 10'd168
   };

   function automatic logic layer_valid(input logic [3:0] layer);
      return layer < 4'(NUM_LAYERS);
   endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding {data, idx, last} beats between the SRAM and the weight port.
// Head entry is held stable until popped; flush empties it in one edge.
module weight_skid_fifo #(
   parameter int unsigned Width = 19
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [Width-1:0] wdata_i,
   output logic [Width-1:0] rdata_o,
   output logic             valid_o,
   output logic [1:0]       occ_o
);

   logic [Width-1:0] mem_q [2];
   logic             wr_ptr_q, rd_ptr_q;
   logic [1:0]       occ_q, occ_d;
   logic             do_pop;

   assign do_pop = pop_i & (occ_q != 2'd0);

   always_comb begin
      occ_d = occ_q;
      unique case ({push_i, do_pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else if (flush_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) rd_ptr_q <= ~rd_ptr_q;
         occ_q <= occ_d;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign valid_o = (occ_q != 2'd0);
   assign occ_o   = occ_q;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Streams one layer of INT8 weights from the weight SRAM to the MAC array weight port.
// Define WEIGHT_FETCH_STATS_EN to build the backpressure stall counter.
module weight_fetch_ctrl
   import dscnn_weight_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic [3:0]        layer_i,
   input  logic              abort_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   input  logic [DATA_W-1:0] sram_data_i,
   output logic              w_valid_o,
   input  logic              w_ready_i,
   output logic [DATA_W-1:0] w_data_o,
   output logic [IDX_W-1:0]  w_idx_o,
   output logic              w_last_o,
   output logic [15:0]       stall_cnt_o
);

   localparam int unsigned BeatW = DATA_W + IDX_W + 1;

   typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [IDX_W-1:0]  len_q, len_d, issue_cnt_q, issue_cnt_d, push_idx_q, push_idx_d;
   logic              inflight_q, done_q, done_d, err_q, err_d;
   logic              layer_ok, accept, issue, issue_last, pop, flush;
   logic [3:0]        layer_sel;
   logic [1:0]        occ;
   logic [BeatW-1:0]  push_beat, head_beat;

   assign layer_ok   = layer_valid(layer_i);
   assign layer_sel  = layer_ok ? layer_i : 4'd0;
   assign accept     = (state_q == StIdle) & start_i & layer_ok;
   assign flush      = abort_i & (state_q != StIdle);
   assign pop        = w_valid_o & w_ready_i;
   assign issue_last = (issue_cnt_q == len_q - IDX_W'(1));
   // Buffer slots already claimed after this cycle must leave room for the new read.
   assign issue = (state_q == StFetch) & ~abort_i &
                  (({1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop}) < 3'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         len_q       <= '0;
         issue_cnt_q <= '0;
         push_idx_q  <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         push_idx_q  <= push_idx_d;
         inflight_q  <= issue;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StFetch;
         StFetch: if (issue && issue_last) state_d = StDrain;
         StDrain: if (pop && w_last_o) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (flush) state_d = StIdle;
   end

   // The address register always presents the next read; issuing commits it.
   always_comb begin
      addr_d      = addr_q;
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      push_idx_d  = push_idx_q;
      if (accept) begin
         addr_d      = LAYER_BASE[layer_sel];
         len_d       = LAYER_LEN[layer_sel];
         issue_cnt_d = '0;
         push_idx_d  = '0;
      end else if (issue) begin
         issue_cnt_d = issue_cnt_q + IDX_W'(1);
         if (!issue_last) addr_d = addr_q + ADDR_W'(1);
      end
      if (inflight_q && !flush) push_idx_d = push_idx_q + IDX_W'(1);
   end

   always_comb begin
      busy_o = (state_q != StIdle);
      done_d = (state_q == StDrain) & pop & w_last_o & ~abort_i;
      err_d  = (state_q == StIdle) & start_i & ~layer_ok;
   end

   assign push_beat = {sram_data_i, push_idx_q, (push_idx_q == len_q - IDX_W'(1))};

   weight_skid_fifo #(
      .Width (BeatW)
   ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (inflight_q),
      .pop_i   (pop),
      .flush_i (flush),
      .wdata_i (push_beat),
      .rdata_o (head_beat),
      .valid_o (w_valid_o),
      .occ_o   (occ)
   );

   assign {w_data_o, w_idx_o, w_last_o} = head_beat;
   assign sram_addr_o = addr_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

`ifdef WEIGHT_FETCH_STATS_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
      end else if (accept) begin
         stall_q <= '0;
      end else if (w_valid_o && !w_ready_i && stall_q != 16'hFFFF) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: random SRAM contents, random/scripted backpressure,
// every beat compared against the layer table derived from the lengths alone.
module tb_weight_fetch_ctrl;
   import dscnn_weight_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_i = 1'b0;
   logic [3:0]        layer_i = 4'd0;
   logic              abort_i = 1'b0;
   logic              busy_o, done_o, err_o;
   logic [ADDR_W-1:0] sram_addr_o;
   logic [DATA_W-1:0] sram_data_i = '0;
   logic              w_valid_o;
   logic              w_ready_i = 1'b0;
   logic [DATA_W-1:0] w_data_o;
   logic [IDX_W-1:0]  w_idx_o;
   logic              w_last_o;
   logic [15:0]       stall_cnt_o;

   weight_fetch_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .layer_i     (layer_i),
      .abort_i     (abort_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .sram_addr_o (sram_addr_o),
      .sram_data_i (sram_data_i),
      .w_valid_o   (w_valid_o),
      .w_ready_i   (w_ready_i),
      .w_data_o    (w_data_o),
      .w_idx_o     (w_idx_o),
      .w_last_o    (w_last_o),
      .stall_cnt_o (stall_cnt_o)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) sram_data_i <= mem[sram_addr_o];

   int len_tab [10] = '{960, 216, 576, 216, 576, 216, 576, 216, 576, 168};
   int base_tab [10];

   int total = 0;
   int bad = 0;
   int q_data[$], q_idx[$], q_last[$], q_addr[$];
   int first_valid, done_cyc, done_cnt, err_cnt, stall_model, unstable, stall_addr;
   logic done_busy;

   task automatic do_start(input logic [3:0] l);
      start_i = 1'b1;
      layer_i = l;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   // mode 0: ready high, 1: random 50%, 2: low for the first 12 cycles.
   task automatic collect(input int mode, input int budget, input bit poke);
      logic r, pv, pl;
      logic [DATA_W-1:0] pd;
      logic [IDX_W-1:0] pi;
      int cyc;
      cyc = 0;
      q_data.delete(); q_idx.delete(); q_last.delete(); q_addr.delete();
      first_valid = -1; done_cyc = -1; done_cnt = 0; err_cnt = 0;
      stall_model = 0; unstable = 0; stall_addr = 0; done_busy = 1'b1;
      pv = 1'b0; pd = '0; pi = '0; pl = 1'b0;
      while (cyc < budget) begin
         case (mode)
            1: r = 1'($urandom_range(0, 1));
            2: r = (cyc >= 12);
            default: r = 1'b1;
         endcase
         w_ready_i = r;
         if (poke) begin
            start_i = (cyc < 100);
            layer_i = (cyc % 2 == 1) ? 4'd0 : 4'd12;
         end
         if (q_addr.size() == 0 || q_addr[$] != int'(sram_addr_o)) q_addr.push_back(int'(sram_addr_o));
         if (mode == 2 && cyc == 11) stall_addr = int'(sram_addr_o);
         if (err_o) err_cnt++;
         if (done_o) begin
            done_cnt++;
            if (done_cyc < 0) begin
               done_cyc  = cyc;
               done_busy = busy_o;
            end
         end
         if (pv && (!w_valid_o || w_data_o !== pd || w_idx_o !== pi || w_last_o !== pl)) unstable++;
         if (w_valid_o && first_valid < 0) first_valid = cyc;
         if (w_valid_o && r) begin
            q_data.push_back(int'(w_data_o));
            q_idx.push_back(int'(w_idx_o));
            q_last.push_back(int'(w_last_o));
         end
         if (w_valid_o && !r) stall_model++;
         pv = w_valid_o && !r; pd = w_data_o; pi = w_idx_o; pl = w_last_o;
         if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
         @(posedge clk); #1;
         cyc++;
      end
      start_i = 1'b0;
      w_ready_i = 1'b0;
   endtask

   function automatic int beat_mismatches(input int l);
      int n;
      n = 0;
      if (q_data.size() != len_tab[l]) n++;
      for (int i = 0; i < q_data.size() && i < len_tab[l]; i++) begin
         if (q_data[i] != int'(mem[base_tab[l] + i]) || q_idx[i] != i ||
             q_last[i] != int'(i == len_tab[l] - 1)) n++;
      end
      return n;
   endfunction

   function automatic int expected_stall();
`ifdef WEIGHT_FETCH_STATS_EN
      return stall_model;
`else
      return 0;
`endif
   endfunction

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      total++; if ({busy_o, done_o, err_o, w_valid_o, w_last_o} !== 5'b0) begin
         bad++; $display("FAIL reset_flags: got %b expected 00000", {busy_o, done_o, err_o, w_valid_o, w_last_o});
      end
      total++; if (sram_addr_o !== '0) begin
         bad++; $display("FAIL reset_addr: got %0h expected 0", sram_addr_o);
      end
      total++; if (w_data_o !== '0 || w_idx_o !== '0) begin
         bad++; $display("FAIL reset_beat: got data %0h idx %0d expected 0", w_data_o, w_idx_o);
      end
      total++; if (stall_cnt_o !== 16'd0) begin
         bad++; $display("FAIL reset_stall: got %0d expected 0", stall_cnt_o);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_layer9_stream();
      int n;
      do_start(4'd9);
      total++; if (busy_o !== 1'b1 || int'(sram_addr_o) != base_tab[9]) begin
         bad++; $display("FAIL l9_start: got busy %b addr %0h expected 1 %0h", busy_o, sram_addr_o, base_tab[9]);
      end
      collect(0, 400, 1'b0);
      n = beat_mismatches(9);
      total++; if (n != 0) begin
         bad++; $display("FAIL l9_beats: got %0d bad beats of %0d expected 0", n, q_data.size());
      end
      n = (q_addr.size() == len_tab[9]) ? 0 : 1;
      for (int i = 0; i < q_addr.size(); i++) if (q_addr[i] != base_tab[9] + i) n++;
      total++; if (n != 0) begin
         bad++; $display("FAIL l9_addr_seq: got %0d errors over %0d addresses expected 0", n, q_addr.size());
      end
      total++; if (first_valid != 2) begin
         bad++; $display("FAIL l9_first_valid: got cycle %0d expected 2", first_valid);
      end
      total++; if (done_cyc != first_valid + len_tab[9] || done_cnt != 1) begin
         bad++; $display("FAIL l9_done: got cycle %0d count %0d expected %0d 1", done_cyc, done_cnt, first_valid + len_tab[9]);
      end
      total++; if (done_busy !== 1'b0) begin
         bad++; $display("FAIL l9_busy_fall: got busy %b at done expected 0", done_busy);
      end
   endtask

   task automatic test_layer0_random();
      int n;
      do_start(4'd0);
      collect(1, 6000, 1'b0);
      n = beat_mismatches(0);
      total++; if (n != 0) begin
         bad++; $display("FAIL l0_beats: got %0d bad beats of %0d expected 0", n, q_data.size());
      end
      total++; if (done_cnt != 1 || unstable != 0) begin
         bad++; $display("FAIL l0_done_stable: got done %0d unstable %0d expected 1 0", done_cnt, unstable);
      end
      total++; if (int'(stall_cnt_o) != expected_stall()) begin
         bad++; $display("FAIL l0_stall_cnt: got %0d expected %0d", stall_cnt_o, expected_stall());
      end
   endtask

   task automatic test_error_and_busy_start();
      int n;
      logic [ADDR_W-1:0] a0;
      a0 = sram_addr_o;
      do_start(4'd12);
      total++; if (err_o !== 1'b1 || busy_o !== 1'b0 || sram_addr_o !== a0) begin
         bad++; $display("FAIL err_pulse: got err %b busy %b addr %0h expected 1 0 %0h", err_o, busy_o, sram_addr_o, a0);
      end
      @(posedge clk); #1;
      total++; if (err_o !== 1'b0) begin
         bad++; $display("FAIL err_width: got %b expected 0", err_o);
      end
      do_start(4'd3);
      collect(1, 2000, 1'b1);
      n = beat_mismatches(3);
      total++; if (n != 0 || done_cnt != 1) begin
         bad++; $display("FAIL busy_start_ignored: got %0d bad beats done %0d expected 0 1", n, done_cnt);
      end
      total++; if (err_cnt != 0) begin
         bad++; $display("FAIL busy_start_err: got %0d err pulses expected 0", err_cnt);
      end
   endtask

   task automatic test_abort();
      int n, cyc, dn, vl;
      do_start(4'd1);
      n = 0; cyc = 0;
      w_ready_i = 1'b1;
      while (n < 50 && cyc < 200) begin
         if (w_valid_o) n++;
         @(posedge clk); #1;
         cyc++;
      end
      w_ready_i = 1'b0;
      abort_i = 1'b1;
      @(posedge clk); #1;
      abort_i = 1'b0;
      total++; if (busy_o !== 1'b0 || w_valid_o !== 1'b0 || done_o !== 1'b0) begin
         bad++; $display("FAIL abort_idle: got busy %b valid %b done %b expected 0 0 0", busy_o, w_valid_o, done_o);
      end
      dn = 0; vl = 0;
      for (int i = 0; i < 4; i++) begin
         if (done_o) dn++;
         if (w_valid_o) vl++;
         @(posedge clk); #1;
      end
      total++; if (dn != 0 || vl != 0) begin
         bad++; $display("FAIL abort_quiet: got done %0d valid %0d expected 0 0", dn, vl);
      end
      do_start(4'd1);
      total++; if (int'(sram_addr_o) != base_tab[1]) begin
         bad++; $display("FAIL abort_restart_addr: got %0h expected %0h", sram_addr_o, base_tab[1]);
      end
      collect(0, 400, 1'b0);
      n = beat_mismatches(1);
      total++; if (n != 0 || done_cnt != 1) begin
         bad++; $display("FAIL abort_restart_beats: got %0d bad beats done %0d expected 0 1", n, done_cnt);
      end
   endtask

   task automatic test_layer5_backpressure();
      int n;
      do_start(4'd5);
      collect(2, 800, 1'b0);
      total++; if (stall_addr - base_tab[5] > 2 || stall_addr < base_tab[5]) begin
         bad++; $display("FAIL l5_reads_in_stall: got addr %0h expected at most %0h", stall_addr, base_tab[5] + 2);
      end
      n = beat_mismatches(5);
      total++; if (n != 0 || done_cnt != 1 || unstable != 0) begin
         bad++; $display("FAIL l5_beats: got %0d bad done %0d unstable %0d expected 0 1 0", n, done_cnt, unstable);
      end
      total++; if (int'(stall_cnt_o) != expected_stall()) begin
         bad++; $display("FAIL l5_stall_cnt: got %0d expected %0d", stall_cnt_o, expected_stall());
      end
   endtask

   task automatic test_reset_midstream();
      int n;
      do_start(4'd2);
      for (int i = 0; i < 30; i++) begin
         w_ready_i = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      total++; if ({busy_o, done_o, err_o, w_valid_o, w_last_o} !== 5'b0 || sram_addr_o !== '0 ||
                   w_data_o !== '0 || w_idx_o !== '0 || stall_cnt_o !== 16'd0) begin
         bad++; $display("FAIL midreset_outputs: got busy %b valid %b addr %0h idx %0d stall %0d expected all 0",
                         busy_o, w_valid_o, sram_addr_o, w_idx_o, stall_cnt_o);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      w_ready_i = 1'b0;
      @(posedge clk); #1;
      do_start(4'd2);
      total++; if (int'(sram_addr_o) != base_tab[2]) begin
         bad++; $display("FAIL midreset_restart_addr: got %0h expected %0h", sram_addr_o, base_tab[2]);
      end
      collect(0, 1000, 1'b0);
      n = beat_mismatches(2);
      total++; if (n != 0 || done_cnt != 1) begin
         bad++; $display("FAIL midreset_beats: got %0d bad beats done %0d expected 0 1", n, done_cnt);
      end
   endtask

   initial begin
      base_tab[0] = 0;
      for (int i = 1; i < 10; i++) base_tab[i] = base_tab[i-1] + len_tab[i-1];
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'($urandom);
      test_reset();
      test_layer9_stream();
      test_layer0_random();
      test_error_and_busy_start();
      test_abort();
      test_layer5_backpressure();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
